// File: rtl/ex_mem_stage_pkg.sv
// ex_mem_stage_pkg
// Shared pipeline control-bit layout used by the EX/MEM stage and its users.
// PIPE_CTRL_WIDTH control bits are carried as one packed vector; the bit
// indices below name each position.
package ex_mem_stage_pkg;

    localparam int PIPE_CTRL_WIDTH = 4;

    localparam int MEM_READ   = 0;
    localparam int MEM_WRITE  = 1;
    localparam int REG_WRITE  = 2;
    localparam int MEM_TO_REG = 3;

    // Control bits of an invalid instruction must never reach MEM.
    function automatic logic [PIPE_CTRL_WIDTH-1:0] gate_ctrl(
        input logic                       valid,
        input logic [PIPE_CTRL_WIDTH-1:0] ctrl
    );
        return valid ? ctrl : '0;
    endfunction

endpackage

// File: rtl/ex_mem_stage_if.sv
// ex_mem_if
// Bundles the hazard controls, the EX-side inputs and the MEM-side outputs of
// the EX/MEM pipeline register.
//   master : the surrounding pipeline (drives stall/flush and ex_*)
//   slave  : the ex_mem_stage block (drives mem_*, redirect and counters)
interface ex_mem_if #(
    parameter int LEN          = 32,
    parameter int REG_ADDR_LEN = 5,
    parameter int CNT_LEN      = 16
);
    logic                    stall;
    logic                    flush;

    logic                    ex_valid;
    logic [LEN-1:0]          ex_alu_out;
    logic                    ex_alu_zero;
    logic [LEN-1:0]          ex_write_data;
    logic [REG_ADDR_LEN-1:0] ex_write_reg;
    logic [LEN-1:0]          ex_branch_pc;
    logic                    ex_branch;
    logic                    ex_mem_read;
    logic                    ex_mem_write;
    logic                    ex_reg_write;
    logic                    ex_mem_to_reg;

    logic                    mem_valid;
    logic [LEN-1:0]          mem_alu_out;
    logic [LEN-1:0]          mem_write_data;
    logic [LEN-1:0]          mem_branch_pc;
    logic [REG_ADDR_LEN-1:0] mem_write_reg;
    logic                    mem_mem_read;
    logic                    mem_mem_write;
    logic                    mem_reg_write;
    logic                    mem_mem_to_reg;

    logic                    pc_redirect;
    logic [LEN-1:0]          redirect_pc;
    logic [CNT_LEN-1:0]      cnt_branch_taken;
    logic [CNT_LEN-1:0]      cnt_bubble;

    modport master (
        output stall, flush,
        output ex_valid, ex_alu_out, ex_alu_zero, ex_write_data, ex_write_reg,
               ex_branch_pc, ex_branch, ex_mem_read, ex_mem_write,
               ex_reg_write, ex_mem_to_reg,
        input  mem_valid, mem_alu_out, mem_write_data, mem_branch_pc,
               mem_write_reg, mem_mem_read, mem_mem_write, mem_reg_write,
               mem_mem_to_reg, pc_redirect, redirect_pc,
               cnt_branch_taken, cnt_bubble
    );

    modport slave (
        input  stall, flush,
        input  ex_valid, ex_alu_out, ex_alu_zero, ex_write_data, ex_write_reg,
               ex_branch_pc, ex_branch, ex_mem_read, ex_mem_write,
               ex_reg_write, ex_mem_to_reg,
        output mem_valid, mem_alu_out, mem_write_data, mem_branch_pc,
               mem_write_reg, mem_mem_read, mem_mem_write, mem_reg_write,
               mem_mem_to_reg, pc_redirect, redirect_pc,
               cnt_branch_taken, cnt_bubble
    );

endinterface

// File: rtl/ex_mem_stage_sat_counter.sv
// sat_counter
// Event counter that adds one per cycle with inc = 1 and sticks at all-ones.
// Ports: clk, reset (sync, active-high, clears count), inc, count.
module sat_counter #(
    parameter int CNT_LEN = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               inc,
    output logic [CNT_LEN-1:0] count
);

    function automatic logic [CNT_LEN-1:0] sat_inc(input logic [CNT_LEN-1:0] v);
        return (&v) ? v : v + CNT_LEN'(1);
    endfunction

    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (inc) begin
            count <= sat_inc(count);
        end
    end

endmodule

// File: rtl/ex_mem_stage.sv
// ex_mem_stage
// EX/MEM pipeline register. Captures the EX-stage result, store data,
// destination register, branch target and control bits; resolves beq from the
// ALU zero flag and redirects the PC one cycle after capture; keeps saturating
// debug counters of taken branches and bubble cycles.
// Ports:
//   clk, reset : clock and synchronous active-high reset
//   bus        : ex_mem_if.slave (stall/flush, ex_* inputs, mem_* outputs,
//                pc_redirect/redirect_pc, cnt_branch_taken/cnt_bubble)
// Update priority on each edge: reset > flush > stall > load.
module ex_mem_stage
    import ex_mem_stage_pkg::*;
#(
    parameter int LEN          = 32,
    parameter int REG_ADDR_LEN = 5,
    parameter int CNT_LEN      = 16
) (
    input  logic     clk,
    input  logic     reset,
    ex_mem_if.slave  bus
);

    logic                       vld_p1;
    logic [LEN-1:0]             alu_out_p1;
    logic [LEN-1:0]             write_data_p1;
    logic [LEN-1:0]             branch_pc_p1;
    logic [REG_ADDR_LEN-1:0]    write_reg_p1;
    logic [PIPE_CTRL_WIDTH-1:0] ctrl_p1;
    logic                       taken_q;

    logic [PIPE_CTRL_WIDTH-1:0] ctrl_in;
    logic                       branch_taken_in;
    logic                       load;
    logic                       inc_taken;
    logic                       inc_bubble;

    always_comb begin
        ctrl_in             = '0;
        ctrl_in[MEM_READ]   = bus.ex_mem_read;
        ctrl_in[MEM_WRITE]  = bus.ex_mem_write;
        ctrl_in[REG_WRITE]  = bus.ex_reg_write;
        ctrl_in[MEM_TO_REG] = bus.ex_mem_to_reg;
    end

    assign branch_taken_in = bus.ex_valid & bus.ex_branch & bus.ex_alu_zero;
    assign load            = ~bus.flush & ~bus.stall;

    // Bubble = next mem_valid is 0 on a non-held edge. A flush wins over stall,
    // so a flush always counts even when stall is also high.
    assign inc_taken  = ~reset & load & branch_taken_in;
    assign inc_bubble = ~reset & (bus.flush | (load & ~bus.ex_valid));

    // EX -> MEM boundary
    always_ff @(posedge clk) begin
        if (reset || bus.flush) begin
            vld_p1        <= 1'b0;
            alu_out_p1    <= '0;
            write_data_p1 <= '0;
            branch_pc_p1  <= '0;
            write_reg_p1  <= '0;
            ctrl_p1       <= '0;
            taken_q       <= 1'b0;
        end else if (!bus.stall) begin
            vld_p1        <= bus.ex_valid;
            alu_out_p1    <= bus.ex_alu_out;
            write_data_p1 <= bus.ex_write_data;
            branch_pc_p1  <= bus.ex_branch_pc;
            write_reg_p1  <= bus.ex_write_reg;
            ctrl_p1       <= gate_ctrl(bus.ex_valid, ctrl_in);
            taken_q       <= branch_taken_in;
        end
    end

    sat_counter #(.CNT_LEN(CNT_LEN)) u_cnt_taken (
        .clk   (clk),
        .reset (reset),
        .inc   (inc_taken),
        .count (bus.cnt_branch_taken)
    );

    sat_counter #(.CNT_LEN(CNT_LEN)) u_cnt_bubble (
        .clk   (clk),
        .reset (reset),
        .inc   (inc_bubble),
        .count (bus.cnt_bubble)
    );

    assign bus.mem_valid      = vld_p1;
    assign bus.mem_alu_out    = alu_out_p1;
    assign bus.mem_write_data = write_data_p1;
    assign bus.mem_branch_pc  = branch_pc_p1;
    assign bus.mem_write_reg  = write_reg_p1;
    assign bus.mem_mem_read   = ctrl_p1[MEM_READ];
    assign bus.mem_mem_write  = ctrl_p1[MEM_WRITE];
    assign bus.mem_reg_write  = ctrl_p1[REG_WRITE];
    assign bus.mem_mem_to_reg = ctrl_p1[MEM_TO_REG];

    // Redirect comes straight from the flop; the hazard unit squashes EX.
    assign bus.pc_redirect    = taken_q;
    assign bus.redirect_pc    = branch_pc_p1;

endmodule
